// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   In-order dual-issue scheduler sitting between the two decode slots and the
//   execute lanes. Holds one instruction pair, issues both slots together when
//   legal, otherwise serializes them. Gates the shared multi-cycle multiplier
//   and freezes permanently once an HLT issues.
//
//   Control bundle: [8]sw [7]lw [6]r [5]branch [4]jmp [3]hlt [2:0]func.
//   A MUL is r && func[2].
//
// Ports
//   clk, reset               rising-edge clock, async active-high reset
//   in_valid / in_ready      decode pair handshake (in_ready is combinational)
//   s0_ctrl, s1_ctrl         slot0 (older) / slot1 (younger) bundles
//   s0_dst                   slot0 destination register
//   s1_src1, s1_src2         slot1 source registers
//   flush                    drop the held pair (taken branch)
//   iss0_valid, iss0_ctrl    registered lane0 issue
//   iss1_valid, iss1_ctrl    registered lane1 issue
//   mul_start                registered pulse: a MUL issued
//   mul_busy                 multiplier occupancy counter nonzero
//   halted                   registered: HLT issued, scheduler frozen
module dual_issue_scheduler #(
    parameter int CTRL_W  = 9,
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] s0_ctrl,
    input  logic [CTRL_W-1:0] s1_ctrl,
    input  logic [REG_W-1:0]  s0_dst,
    input  logic [REG_W-1:0]  s1_src1,
    input  logic [REG_W-1:0]  s1_src2,
    input  logic              flush,
    output logic              iss0_valid,
    output logic [CTRL_W-1:0] iss0_ctrl,
    output logic              iss1_valid,
    output logic [CTRL_W-1:0] iss1_ctrl,
    output logic              mul_start,
    output logic              mul_busy,
    output logic              halted
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {EMPTY, PAIR, SECOND, HALTED} state_t;

    state_t             state, state_n;
    logic [CTRL_W-1:0]  h0_ctrl, h1_ctrl;
    logic [REG_W-1:0]   h0_dst, h1_src1, h1_src2;
    logic [CNT_W-1:0]   mul_cnt;

    logic mul0, mul1, ls0, ls1, blk0, blk1, raw, dual_ok;
    logic issue0, issue1, accept, hlt_issue, mul_issue;

    assign mul_busy = (mul_cnt != '0);

    // Slot decode on the held pair
    assign mul0 = h0_ctrl[6] & h0_ctrl[2];
    assign mul1 = h1_ctrl[6] & h1_ctrl[2];
    assign ls0  = h0_ctrl[8] | h0_ctrl[7];
    assign ls1  = h1_ctrl[8] | h1_ctrl[7];
    assign blk0 = mul0 & (mul_busy | mul_start);
    assign blk1 = mul1 & (mul_busy | mul_start);

    // src2 only matters when slot1 actually reads it (r, sw, branch)
    assign raw = (h0_ctrl[6] | h0_ctrl[7]) && (h0_dst != '0) &&
                 ((h0_dst == h1_src1) ||
                  ((h1_ctrl[6] | h1_ctrl[8] | h1_ctrl[5]) && (h0_dst == h1_src2)));

    assign dual_ok = !blk0 && !blk1 && !(ls0 && ls1) && !(mul0 && mul1) &&
                     !(h0_ctrl[5] | h0_ctrl[4] | h0_ctrl[3]) && !raw;

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        issue0    = 1'b0;
        issue1    = 1'b0;
        accept    = 1'b0;
        hlt_issue = 1'b0;
        mul_issue = 1'b0;
        case (state)
            EMPTY:  in_ready = !flush;
            PAIR: begin
                if (!flush) begin
                    if (dual_ok) begin
                        issue0   = 1'b1;
                        issue1   = 1'b1;
                        in_ready = !h1_ctrl[3];
                    end else if (!blk0) begin
                        issue0 = 1'b1;
                    end
                end
            end
            SECOND: begin
                if (!flush && !blk1) begin
                    issue1   = 1'b1;
                    in_ready = !h1_ctrl[3];
                end
            end
            default: ;
        endcase
        accept    = in_valid && in_ready;
        hlt_issue = (issue0 && h0_ctrl[3]) || (issue1 && h1_ctrl[3]);
        mul_issue = (issue0 && mul0) || (issue1 && mul1);
        // Priority order: halting wins, then a new pair, then flush/drain.
        // A slot0-only HLT lands here too, which discards slot1.
        if (hlt_issue)
            state_n = HALTED;
        else if (accept)
            state_n = PAIR;
        else if (flush && state != HALTED)
            state_n = EMPTY;
        else if (issue1)
            state_n = EMPTY;
        else if (issue0)
            state_n = SECOND;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            h0_ctrl    <= '0;
            h1_ctrl    <= '0;
            h0_dst     <= '0;
            h1_src1    <= '0;
            h1_src2    <= '0;
            mul_cnt    <= '0;
            iss0_valid <= 1'b0;
            iss0_ctrl  <= '0;
            iss1_valid <= 1'b0;
            iss1_ctrl  <= '0;
            mul_start  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_n;
            iss0_valid <= issue0;
            iss0_ctrl  <= issue0 ? h0_ctrl : '0;
            iss1_valid <= issue1;
            iss1_ctrl  <= issue1 ? h1_ctrl : '0;
            mul_start  <= mul_issue;
            halted     <= (state_n == HALTED);
            // Counter loads on the issuing edge, so mul_busy covers the
            // MUL_LAT cycles that follow the issue.
            if (mul_issue)
                mul_cnt <= CNT_W'(MUL_LAT);
            else if (mul_cnt != '0)
                mul_cnt <= mul_cnt - 1'b1;
            if (accept) begin
                h0_ctrl <= s0_ctrl;
                h1_ctrl <= s1_ctrl;
                h0_dst  <= s0_dst;
                h1_src1 <= s1_src1;
                h1_src2 <= s1_src2;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

    localparam logic [8:0] ADD = 9'h040;
    localparam logic [8:0] SUB = 9'h041;
    localparam logic [8:0] ORR = 9'h043;
    localparam logic [8:0] LW  = 9'h080;
    localparam logic [8:0] SW  = 9'h100;
    localparam logic [8:0] MUL = 9'h044;
    localparam logic [8:0] HLT = 9'h008;
    localparam logic [8:0] JMP = 9'h010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [8:0] s0_ctrl = '0;
    logic [8:0] s1_ctrl = '0;
    logic [4:0] s0_dst = '0;
    logic [4:0] s1_src1 = '0;
    logic [4:0] s1_src2 = '0;
    logic       in_ready, iss0_valid, iss1_valid, mul_start, mul_busy, halted;
    logic [8:0] iss0_ctrl, iss1_ctrl;

    int cyc = 0;
    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        int         cyc;
        logic       v0;
        logic [8:0] c0;
        logic       v1;
        logic [8:0] c1;
        logic       ms;
    } exp_t;

    exp_t q[$];
    exp_t e;

    dual_issue_scheduler #(.CTRL_W(9), .REG_W(5), .MUL_LAT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .s0_ctrl(s0_ctrl), .s1_ctrl(s1_ctrl), .s0_dst(s0_dst),
        .s1_src1(s1_src1), .s1_src2(s1_src2), .flush(flush),
        .iss0_valid(iss0_valid), .iss0_ctrl(iss0_ctrl),
        .iss1_valid(iss1_valid), .iss1_ctrl(iss1_ctrl),
        .mul_start(mul_start), .mul_busy(mul_busy), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with issue activity pops one expected record
    always @(negedge clk) begin
        if (iss0_valid || iss1_valid || mul_start) begin
            ncmp++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_issue cyc=%0d: got v0=%b c0=%h v1=%b c1=%h ms=%b, required no issue",
                         cyc, iss0_valid, iss0_ctrl, iss1_valid, iss1_ctrl, mul_start);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.v0 !== iss0_valid || e.c0 !== iss0_ctrl ||
                    e.v1 !== iss1_valid || e.c1 !== iss1_ctrl || e.ms !== mul_start) begin
                    nerr++;
                    $display("FAIL issue cyc=%0d v0=%b c0=%h v1=%b c1=%h ms=%b, required cyc=%0d v0=%b c0=%h v1=%b c1=%h ms=%b",
                             cyc, iss0_valid, iss0_ctrl, iss1_valid, iss1_ctrl, mul_start,
                             e.cyc, e.v0, e.c0, e.v1, e.c1, e.ms);
                end
            end
        end
    end

    task automatic expect_iss(input int c, input logic v0, input logic [8:0] c0,
                              input logic v1, input logic [8:0] c1, input logic ms);
        exp_t x;
        x.cyc = c; x.v0 = v0; x.c0 = c0; x.v1 = v1; x.c1 = c1; x.ms = ms;
        q.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a pair and wait (bounded) for acceptance; acc = edge count of acceptance
    task automatic send(input logic [8:0] c0, input logic [8:0] c1, input logic [4:0] d,
                        input logic [4:0] a1, input logic [4:0] a2, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        s0_ctrl = c0; s1_ctrl = c1; s0_dst = d; s1_src1 = a1; s1_src2 = a2;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            ncmp++;
            nerr++;
            $display("FAIL accept_timeout cyc=%0d: got in_ready=0, required 1", cyc);
            in_valid = 1'b0;
            acc = -100;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int a;
        idle(2);
        chk("rst_iss0_valid", 32'(iss0_valid), 0);
        chk("rst_iss1_valid", 32'(iss1_valid), 0);
        chk("rst_iss0_ctrl", 32'(iss0_ctrl), 0);
        chk("rst_iss1_ctrl", 32'(iss1_ctrl), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_mul_busy", 32'(mul_busy), 0);
        chk("rst_halted", 32'(halted), 0);
        reset = 1'b0;
        idle(1);

        // ADD + SUB, independent: dual issue one cycle after acceptance
        send(ADD, SUB, 5'd3, 5'd4, 5'd5, a);
        expect_iss(a + 1, 1, ADD, 1, SUB, 0);
        chk("rdy_dual", 32'(in_ready), 1);
        idle(3);

        // LW + SW: shared memory port, serialized
        send(LW, SW, 5'd1, 5'd2, 5'd3, a);
        expect_iss(a + 1, 1, LW, 0, 9'h0, 0);
        expect_iss(a + 2, 0, 9'h0, 1, SW, 0);
        chk("rdy_lwsw_pair", 32'(in_ready), 0);
        idle(1);
        chk("rdy_lwsw_second", 32'(in_ready), 1);
        idle(3);

        // RAW on src1 -> serialized
        send(ADD, ORR, 5'd3, 5'd3, 5'd7, a);
        expect_iss(a + 1, 1, ADD, 0, 9'h0, 0);
        expect_iss(a + 2, 0, 9'h0, 1, ORR, 0);
        idle(3);

        // Destination r0 never hazards -> dual
        send(ADD, ORR, 5'd0, 5'd0, 5'd0, a);
        expect_iss(a + 1, 1, ADD, 1, ORR, 0);
        idle(3);

        // src2 hazard counts for SW
        send(ADD, SW, 5'd5, 5'd1, 5'd5, a);
        expect_iss(a + 1, 1, ADD, 0, 9'h0, 0);
        expect_iss(a + 2, 0, 9'h0, 1, SW, 0);
        idle(3);

        // src2 ignored for LW -> dual
        send(ADD, LW, 5'd5, 5'd1, 5'd5, a);
        expect_iss(a + 1, 1, ADD, 1, LW, 0);
        idle(3);

        // Slot0 JMP never pairs
        send(JMP, ADD, 5'd0, 5'd1, 5'd2, a);
        expect_iss(a + 1, 1, JMP, 0, 9'h0, 0);
        expect_iss(a + 2, 0, 9'h0, 1, ADD, 0);
        idle(3);

        // Flush while slot1 is held in SECOND: slot1 dropped
        send(LW, SW, 5'd1, 5'd2, 5'd3, a);
        expect_iss(a + 1, 1, LW, 0, 9'h0, 0);
        idle(1);
        flush = 1'b1;
        #1;
        chk("rdy_flush", 32'(in_ready), 0);
        idle(1);
        flush = 1'b0;
        idle(3);

        // MUL + MUL: second MUL waits out the occupancy window
        send(MUL, MUL, 5'd1, 5'd2, 5'd3, a);
        expect_iss(a + 1, 1, MUL, 0, 9'h0, 1);
        expect_iss(a + 6, 0, 9'h0, 1, MUL, 1);
        idle(1);
        chk("mul_busy_first", 32'(mul_busy), 1);
        idle(1);
        chk("rdy_mul_blocked", 32'(in_ready), 0);
        idle(2);
        chk("mul_busy_last", 32'(mul_busy), 1);
        idle(1);
        chk("mul_busy_clear", 32'(mul_busy), 0);
        idle(6);
        chk("mul_busy_idle", 32'(mul_busy), 0);

        // Reset while slot1 MUL waits in SECOND with the multiplier busy
        send(MUL, MUL, 5'd1, 5'd2, 5'd3, a);
        expect_iss(a + 1, 1, MUL, 0, 9'h0, 1);
        idle(2);
        chk("pre_rst_busy", 32'(mul_busy), 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(mul_busy), 0);
        chk("midrst_iss0", 32'(iss0_valid), 0);
        chk("midrst_iss1", 32'(iss1_valid), 0);
        chk("midrst_halted", 32'(halted), 0);
        idle(1);
        reset = 1'b0;
        send(ADD, SUB, 5'd3, 5'd4, 5'd5, a);
        expect_iss(a + 1, 1, ADD, 1, SUB, 0);
        idle(3);

        // HLT in slot0: ADD discarded, scheduler frozen
        send(HLT, ADD, 5'd0, 5'd0, 5'd0, a);
        expect_iss(a + 1, 1, HLT, 0, 9'h0, 0);
        chk("rdy_hlt", 32'(in_ready), 0);
        idle(1);
        chk("halted_set", 32'(halted), 1);
        s0_ctrl = ADD; s1_ctrl = SUB; in_valid = 1'b1;
        idle(4);
        chk("rdy_halted", 32'(in_ready), 0);
        flush = 1'b1;
        idle(2);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("halted_after_flush", 32'(halted), 1);
        chk("rdy_halted_late", 32'(in_ready), 0);

        // Reset leaves HALTED; normal operation resumes
        reset = 1'b1;
        idle(1);
        chk("rst_clears_halt", 32'(halted), 0);
        reset = 1'b0;
        send(ADD, SUB, 5'd3, 5'd4, 5'd5, a);
        expect_iss(a + 1, 1, ADD, 1, SUB, 0);
        idle(4);

        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
